syndrome_round_assembler: RTL and testbench



---
 rtl/qec_pkg.sv | 23 ++
 rtl/syndrome_fifo.sv | 66 ++++++
 rtl/syndrome_round_assembler.sv | 133 +++++++++++++
 tb/tb_syndrome_round_assembler.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/qec_pkg.sv
// ============================================================================
// Module   : qec_pkg
// Purpose  : Shared widths, types and FSM encoding for the decoder front end.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package qec_pkg;
    localparam int NUM_STAB        = 49;
    localparam int BEAT_W          = 7;
    localparam int BEATS_PER_ROUND = NUM_STAB / BEAT_W;
    localparam int ROUND_ID_W      = 8;

    typedef logic [NUM_STAB-1:0]   syndrome_t;
    typedef logic [ROUND_ID_W-1:0] round_id_t;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        DISCARD = 1'b1
    } asm_state_t;
endpackage

`default_nettype wire

// File: rtl/syndrome_fifo.sv
// ============================================================================
// Module   : syndrome_fifo
// Purpose  : Synchronous width/depth FIFO; push into a full FIFO succeeds
//            only when a pop happens in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module syndrome_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] c_LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] c_DEPTH    = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_pop  = pop && (r_count != '0);
    assign w_do_push = push && ((r_count != c_DEPTH) || w_do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= (r_wr_ptr == c_LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign pop_data = r_mem[r_rd_ptr];
    assign full     = (r_count == c_DEPTH);
    assign empty    = (r_count == '0);
endmodule

`default_nettype wire

// File: rtl/syndrome_round_assembler.sv
// ============================================================================
// Module   : syndrome_round_assembler
// Purpose  : Packs measurement beats into rounds, XORs against the previous
//            round to form detection events, and queues them for the decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module syndrome_round_assembler #(
    parameter int NUM_STAB   = qec_pkg::NUM_STAB,
    parameter int BEAT_W     = qec_pkg::BEAT_W,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 meas_valid,
    input  logic [BEAT_W-1:0]    meas_data,
    input  logic                 meas_last,
    output logic [NUM_STAB-1:0]  syndrome,
    output logic                 syndrome_valid,
    input  logic                 syndrome_ready,
    output qec_pkg::round_id_t   round_id,
    output logic                 frame_err,
    output logic                 overflow,
    input  logic                 clear_flags
);
    import qec_pkg::*;

    localparam int BEATS = NUM_STAB / BEAT_W;
    localparam int BCNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int ID_W   = $bits(round_id_t);
    localparam logic [BCNT_W-1:0] c_LAST_BEAT = BCNT_W'(BEATS - 1);

    asm_state_t          r_state;
    logic [BCNT_W-1:0]   r_beat_cnt;
    logic [NUM_STAB-1:0] r_round_buf;
    logic [NUM_STAB-1:0] r_prev_round;
    round_id_t           r_round_cnt;
    logic                r_frame_err;
    logic                r_overflow;

    logic                w_beat;
    logic                w_at_end;
    logic                w_complete;
    logic                w_frame_bad;
    logic                w_pop;
    logic                w_push;
    logic                w_drop;
    logic                w_full;
    logic                w_empty;
    logic [NUM_STAB-1:0] w_round;
    logic [NUM_STAB-1:0] w_det;
    round_id_t           w_next_id;
    logic [NUM_STAB+ID_W-1:0] w_head;

    assign w_beat      = meas_valid && (r_state == COLLECT);
    assign w_at_end    = (r_beat_cnt == c_LAST_BEAT);
    assign w_complete  = w_beat && meas_last && w_at_end;
    // Early meas_last or a missing meas_last on the final slot both misframe the round.
    assign w_frame_bad = w_beat && (meas_last != w_at_end);

    // The final beat is not yet in round_buf, so splice it in directly.
    assign w_round   = {meas_data, r_round_buf[NUM_STAB-BEAT_W-1:0]};
    assign w_det     = w_round ^ r_prev_round;
    assign w_next_id = r_round_cnt + 1'b1;

    assign w_pop  = syndrome_valid && syndrome_ready;
    assign w_push = w_complete && (!w_full || w_pop);
    assign w_drop = w_complete && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= COLLECT;
            r_beat_cnt   <= '0;
            r_round_buf  <= '0;
            r_prev_round <= '0;
            r_round_cnt  <= '0;
            r_frame_err  <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            if (meas_valid) begin
                case (r_state)
                    COLLECT: begin
                        r_round_buf[r_beat_cnt*BEAT_W +: BEAT_W] <= meas_data;
                        if (w_complete) begin
                            r_prev_round <= w_round;
                            r_round_cnt  <= w_next_id;
                            r_beat_cnt   <= '0;
                        end else if (w_frame_bad) begin
                            r_beat_cnt <= '0;
                            if (!meas_last) begin
                                r_state <= DISCARD;
                            end
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 1'b1;
                        end
                    end
                    DISCARD: begin
                        if (meas_last) begin
                            r_state    <= COLLECT;
                            r_beat_cnt <= '0;
                        end
                    end
                endcase
            end
            // A same-cycle set beats clear_flags.
            r_frame_err <= w_frame_bad | (r_frame_err & ~clear_flags);
            r_overflow  <= w_drop      | (r_overflow  & ~clear_flags);
        end
    end

    syndrome_fifo #(
        .WIDTH (NUM_STAB + ID_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data ({w_det, w_next_id}),
        .pop       (w_pop),
        .pop_data  (w_head),
        .full      (w_full),
        .empty     (w_empty)
    );

    assign syndrome       = w_head[NUM_STAB+ID_W-1:ID_W];
    assign round_id       = w_head[ID_W-1:0];
    assign syndrome_valid = !w_empty;
    assign frame_err      = r_frame_err;
    assign overflow       = r_overflow;
endmodule

`default_nettype wire

// File: tb/tb_syndrome_round_assembler.sv
// ============================================================================
// Module   : tb_syndrome_round_assembler
// Purpose  : Directed stimulus with a queue scoreboard for the round assembler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_syndrome_round_assembler;
    logic        clk = 1'b0;
    logic        reset;
    logic        meas_valid;
    logic [6:0]  meas_data;
    logic        meas_last;
    logic [48:0] syndrome;
    logic        syndrome_valid;
    logic        syndrome_ready;
    logic [7:0]  round_id;
    logic        frame_err;
    logic        overflow;
    logic        clear_flags;

    typedef struct packed {
        logic [48:0] syn;
        logic [7:0]  id;
    } exp_t;

    exp_t exp_q[$];
    int   total     = 0;
    int   bad       = 0;
    int   pop_count = 0;

    always #5 clk = ~clk;

    syndrome_round_assembler dut (
        .clk            (clk),
        .reset          (reset),
        .meas_valid     (meas_valid),
        .meas_data      (meas_data),
        .meas_last      (meas_last),
        .syndrome       (syndrome),
        .syndrome_valid (syndrome_valid),
        .syndrome_ready (syndrome_ready),
        .round_id       (round_id),
        .frame_err      (frame_err),
        .overflow       (overflow),
        .clear_flags    (clear_flags)
    );

    // Head is compared every cycle it is valid, so stalled entries must stay stable.
    always @(negedge clk) begin
        if (!reset && syndrome_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_output: syndrome=%h round_id=%0d, required no entry",
                         syndrome, round_id);
            end else begin
                if (syndrome !== exp_q[0].syn || round_id !== exp_q[0].id) begin
                    bad++;
                    $display("FAIL head: syndrome=%h round_id=%0d, required syndrome=%h round_id=%0d",
                             syndrome, round_id, exp_q[0].syn, exp_q[0].id);
                end
                if (syndrome_ready) begin
                    exp_q.delete(0);
                    pop_count++;
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_flags = 1'b1;
        @(posedge clk);
        #1 clear_flags = 1'b0;
    endtask

    task automatic send_round(input logic [6:0] d, input int nbeats, input bit last_at_end,
                              input bit pop_on_last, input bit gap, input bit exp_push,
                              input logic [48:0] exp_syn, input logic [7:0] exp_id);
        for (int i = 0; i < nbeats; i++) begin
            if (gap && i == 3) begin
                meas_valid = 1'b0;
                meas_last  = 1'b0;
                @(posedge clk);
                #1;
            end
            meas_valid = 1'b1;
            meas_data  = d;
            meas_last  = last_at_end && (i == nbeats - 1);
            if (i == nbeats - 1) begin
                if (exp_push) exp_q.push_back('{syn: exp_syn, id: exp_id});
                if (pop_on_last) syndrome_ready = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        meas_valid = 1'b0;
        meas_last  = 1'b0;
        if (pop_on_last) syndrome_ready = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        meas_valid     = 1'b0;
        meas_data      = '0;
        meas_last      = 1'b0;
        syndrome_ready = 1'b1;
        clear_flags    = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;

        check("reset_syndrome", 64'(syndrome), 64'h0);
        check("reset_valid", 64'(syndrome_valid), 64'h0);
        check("reset_round_id", 64'(round_id), 64'h0);
        check("reset_frame_err", 64'(frame_err), 64'h0);
        check("reset_overflow", 64'(overflow), 64'h0);

        // First round: raw measurement, valid right after the last beat.
        send_round(7'h01, 7, 1, 0, 0, 1, 49'h0040810204081, 8'd1);
        check("first_round_latency", 64'(syndrome_valid), 64'h1);
        @(posedge clk); #1;

        // Identical round with an idle gap mid-round.
        send_round(7'h01, 7, 1, 0, 1, 1, 49'h0, 8'd2);
        @(posedge clk); #1;

        // Short round flags and pushes nothing.
        send_round(7'h55, 4, 1, 0, 0, 0, 49'h0, 8'd0);
        check("short_frame_err", 64'(frame_err), 64'h1);
        check("short_no_push", 64'(syndrome_valid), 64'h0);
        send_round(7'h7F, 7, 1, 0, 0, 1, {7{7'h7E}}, 8'd3);
        pulse_clear();
        check("frame_err_cleared", 64'(frame_err), 64'h0);

        // Missing meas_last discards until the next meas_last.
        send_round(7'h12, 7, 0, 0, 0, 0, 49'h0, 8'd0);
        check("missing_last_frame_err", 64'(frame_err), 64'h1);
        send_round(7'h12, 2, 1, 0, 0, 0, 49'h0, 8'd0);
        check("discard_no_push", 64'(syndrome_valid), 64'h0);
        send_round(7'h7F, 7, 1, 0, 0, 1, 49'h0, 8'd4);
        pulse_clear();

        // Consumer stall: third round dropped while clear_flags is held.
        do_reset();
        syndrome_ready = 1'b0;
        send_round(7'h11, 7, 1, 0, 0, 1, {7{7'h11}}, 8'd1);
        send_round(7'h22, 7, 1, 0, 0, 1, {7{7'h33}}, 8'd2);
        clear_flags = 1'b1;
        send_round(7'h44, 7, 1, 0, 0, 0, 49'h0, 8'd0);
        check("overflow_set_wins", 64'(overflow), 64'h1);
        clear_flags = 1'b0;
        check("stall_valid", 64'(syndrome_valid), 64'h1);
        syndrome_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("stall_drained", 64'(exp_q.size()), 64'h0);
        check("stall_empty", 64'(syndrome_valid), 64'h0);
        send_round(7'h08, 7, 1, 0, 0, 1, {7{7'h4C}}, 8'd4);
        @(posedge clk); #1;
        pulse_clear();
        check("overflow_cleared", 64'(overflow), 64'h0);

        // Push and pop together on a full FIFO.
        do_reset();
        syndrome_ready = 1'b0;
        send_round(7'h01, 7, 1, 0, 0, 1, {7{7'h01}}, 8'd1);
        send_round(7'h03, 7, 1, 0, 0, 1, {7{7'h02}}, 8'd2);
        send_round(7'h07, 7, 1, 1, 0, 1, {7{7'h04}}, 8'd3);
        check("full_pushpop_no_overflow", 64'(overflow), 64'h0);
        pop_count = 0;
        syndrome_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("full_pushpop_depth", 64'(pop_count), 64'h2);

        // Reset in the middle of a round with an entry queued.
        do_reset();
        syndrome_ready = 1'b0;
        send_round(7'h0F, 7, 1, 0, 0, 1, {7{7'h0F}}, 8'd1);
        send_round(7'h3C, 5, 0, 0, 0, 0, 49'h0, 8'd0);
        do_reset();
        check("midreset_valid", 64'(syndrome_valid), 64'h0);
        check("midreset_round_id", 64'(round_id), 64'h0);
        syndrome_ready = 1'b1;
        send_round(7'h2A, 7, 1, 0, 0, 1, {7{7'h2A}}, 8'd1);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(posedge clk);
        end
        #1;
        check("final_drain", 64'(exp_q.size()), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire
